// File: rtl/fir_pkg.sv
// fir_pkg: shared state encoding, sizing helper and default filter dimensions
package fir_pkg;

    localparam int COEF_WIDTH_DEF = 8;
    localparam int ORDER_DEF      = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_coef_buf.sv
// fir_coef_buf: coefficient register file, one write port and one registered read port
module fir_coef_buf #(
    parameter int W  = 8,
    parameter int N  = 6,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [N];
    logic [W-1:0] rdata_q;

    // storage is deliberately unreset; contents are only meaningful after a full fill
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // read register doubles as the filter's coef_in, so it clears on reset and holds when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fir_coef_loader.sv
// fir_coef_loader: collects a coefficient set then shifts it serially into the filter
module fir_coef_loader
    import fir_pkg::*;
#(
    parameter int coef_width = COEF_WIDTH_DEF,
    parameter int order      = ORDER_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  wr_valid,
    input  logic [coef_width-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  coef_shift_en,
    output logic [coef_width-1:0] coef_in_o,
    output logic                  data_hold,
    output logic                  busy,
    output logic                  done,
    input  logic                  abort
);

    localparam int PW = clog2(order);
    localparam logic [PW-1:0] LAST = PW'(order - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          we, re;
    logic          wr_ready_q, shift_q, busy_q, done_q;

    // next state and pointers; abort overrides every transition
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        we       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d  = ST_FILL;
                    wr_ptr_d = '0;
                end
            end
            ST_FILL: begin
                if (wr_valid) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                    if (wr_ptr_q == LAST) begin
                        state_d  = ST_SHIFT;
                        rd_ptr_d = '0;
                    end
                end
            end
            ST_SHIFT: begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                if (rd_ptr_q == LAST) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_IDLE;
        re = (state_d == ST_SHIFT);
    end

    // state and pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // outputs registered from next state so they align with the state they describe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ready_q <= 1'b0;
            shift_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            wr_ready_q <= (state_d == ST_FILL);
            shift_q    <= (state_d == ST_SHIFT);
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= (state_d == ST_DONE);
        end
    end

    // read address is the next rd_ptr so the entry lands on coef_in_o with its shift beat
    fir_coef_buf #(
        .W  (coef_width),
        .N  (order),
        .AW (PW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .re_i    (re),
        .raddr_i (rd_ptr_d),
        .rdata_o (coef_in_o)
    );

    assign wr_ready      = wr_ready_q;
    assign coef_shift_en = shift_q;
    assign data_hold     = shift_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_fir_coef_loader.sv
// tb_fir_coef_loader: randomized check of the coefficient loader against a queue model
module tb_fir_coef_loader;

    logic        clk, rst;
    logic        load_start, wr_valid, abort;
    logic [7:0]  wr_data;
    logic        wr_ready, coef_shift_en, data_hold, busy, done;
    logic [7:0]  coef_in_o;

    logic        load_start2, wr_valid2, abort2;
    logic [15:0] wr_data2;
    logic        wr_ready2, coef_shift_en2, data_hold2, busy2, done2;
    logic [15:0] coef_in_o2;

    logic [7:0]  exp_q[$];
    int          n_vec, n_bad;

    fir_coef_loader #(.coef_width(8), .order(6)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .wr_valid(wr_valid),
        .wr_data(wr_data), .wr_ready(wr_ready), .coef_shift_en(coef_shift_en),
        .coef_in_o(coef_in_o), .data_hold(data_hold), .busy(busy), .done(done),
        .abort(abort)
    );

    fir_coef_loader #(.coef_width(16), .order(2)) dut2 (
        .clk(clk), .rst(rst), .load_start(load_start2), .wr_valid(wr_valid2),
        .wr_data(wr_data2), .wr_ready(wr_ready2), .coef_shift_en(coef_shift_en2),
        .coef_in_o(coef_in_o2), .data_hold(data_hold2), .busy(busy2), .done(done2),
        .abort(abort2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // start a set and write six coefficients; the model is simply the ordered list accepted
    task automatic load6(input bit rnd, input bit gaps, input bit ls_in_fill);
        logic [7:0] d;
        exp_q.delete();
        load_start = 1'b1;
        tick;
        load_start = 1'b0;
        check("fill_ready", wr_ready, 1);
        check("fill_busy", busy, 1);
        for (int i = 0; i < 6; i++) begin
            if (gaps) begin
                wr_valid = 1'b0;
                wr_data  = 8'($urandom);
                tick;
                check("gap_ready", wr_ready, 1);
            end
            d = rnd ? 8'($urandom) : 8'(i + 1);
            wr_valid   = 1'b1;
            wr_data    = d;
            load_start = ls_in_fill && (i == 2);
            exp_q.push_back(d);
            tick;
            wr_valid   = 1'b0;
            load_start = 1'b0;
            check("ready_after_wr", wr_ready, (i < 5) ? 1 : 0);
        end
    endtask

    // walk the shift beats; optionally abort or reset on a chosen beat
    task automatic shift6(input int abort_at, input int rst_at, input bit ls);
        for (int b = 0; b < 6; b++) begin
            check("shift_en", coef_shift_en, 1);
            check("coef", coef_in_o, exp_q[b]);
            check("hold", data_hold, 1);
            check("ready_in_shift", wr_ready, 0);
            check("done_early", done, 0);
            if (b == rst_at) begin
                #2 rst = 1'b1;
                #1;
                check("rst_shift_en", coef_shift_en, 0);
                check("rst_coef", coef_in_o, 0);
                check("rst_hold", data_hold, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                #2 rst = 1'b0;
                tick;
                check("post_rst_ready", wr_ready, 0);
                check("post_rst_busy", busy, 0);
                check("post_rst_shift", coef_shift_en, 0);
                return;
            end
            if (b == abort_at) begin
                abort = 1'b1;
                tick;
                abort = 1'b0;
                check("abort_shift_en", coef_shift_en, 0);
                check("abort_hold", data_hold, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                tick;
                check("abort_no_done", done, 0);
                return;
            end
            load_start = ls;
            tick;
            load_start = 1'b0;
        end
        check("done", done, 1);
        check("shift_off", coef_shift_en, 0);
        check("busy_at_done", busy, 1);
        tick;
        check("done_pulse", done, 0);
        check("busy_after", busy, 0);
        check("coef_hold", coef_in_o, exp_q[5]);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1;
        {load_start, wr_valid, abort, wr_data} = '0;
        {load_start2, wr_valid2, abort2, wr_data2} = '0;
        tick;
        tick;
        check("rst_ready", wr_ready, 0);
        check("rst_shift", coef_shift_en, 0);
        check("rst_coef0", coef_in_o, 0);
        check("rst_hold0", data_hold, 0);
        check("rst_busy0", busy, 0);
        check("rst_done0", done, 0);
        check("rst_coef2", coef_in_o2, 0);
        check("rst_busy2", busy2, 0);
        rst = 1'b0;
        tick;
        // writes offered while idle are never accepted
        wr_valid = 1'b1;
        wr_data  = 8'hAA;
        tick;
        tick;
        check("idle_ready", wr_ready, 0);
        check("idle_busy", busy, 0);
        wr_valid = 1'b0;
        // abort beats load_start in IDLE
        abort      = 1'b1;
        load_start = 1'b1;
        tick;
        abort      = 1'b0;
        load_start = 1'b0;
        check("abort_idle_busy", busy, 0);
        check("abort_idle_ready", wr_ready, 0);
        tick;
        check("abort_idle_busy2", busy, 0);
        // back-to-back 1..6, then with gaps
        load6(0, 0, 0);
        shift6(-1, -1, 0);
        load6(0, 1, 0);
        shift6(-1, -1, 0);
        // abort on third shift beat, then a fresh set
        load6(1, 0, 0);
        shift6(2, -1, 0);
        load6(1, 0, 0);
        shift6(-1, -1, 0);
        // load_start during fill and shift is ignored
        load6(1, 1, 1);
        shift6(-1, -1, 1);
        // abort mid-fill discards the partial set
        load_start = 1'b1;
        tick;
        load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'($urandom);
            tick;
        end
        wr_valid = 1'b0;
        abort    = 1'b1;
        tick;
        abort = 1'b0;
        check("abort_fill_busy", busy, 0);
        check("abort_fill_ready", wr_ready, 0);
        load6(1, 0, 0);
        shift6(-1, -1, 0);
        // async reset on fourth shift beat
        load6(1, 0, 0);
        shift6(-1, 3, 0);
        load6(1, 1, 0);
        shift6(-1, -1, 0);
        // random sets, occasionally aborted
        repeat (20) begin
            load6(1, 1'($urandom), 1'($urandom));
            shift6(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1, -1, 1'($urandom));
        end
        // order 2, 16-bit extremes
        load_start2 = 1'b1;
        tick;
        load_start2 = 1'b0;
        check("o2_ready", wr_ready2, 1);
        wr_valid2 = 1'b1;
        wr_data2  = 16'h8000;
        tick;
        check("o2_ready_mid", wr_ready2, 1);
        wr_data2 = 16'h7FFF;
        tick;
        wr_valid2 = 1'b0;
        check("o2_shift0", coef_shift_en2, 1);
        check("o2_coef0", coef_in_o2, 16'h8000);
        check("o2_ready_off", wr_ready2, 0);
        tick;
        check("o2_shift1", coef_shift_en2, 1);
        check("o2_coef1", coef_in_o2, 16'h7FFF);
        check("o2_done_early", done2, 0);
        tick;
        check("o2_done", done2, 1);
        check("o2_shift_off", coef_shift_en2, 0);
        tick;
        check("o2_done_pulse", done2, 0);
        check("o2_busy", busy2, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
